// File: rtl/fetch_unit.sv
// Instruction fetch stage: credit-limited sequential fetch into a {pc, instr} FIFO,
// presented to decode over valid/ready, with redirect flushing and stale-response dropping.
module fetch_unit #(
    parameter int              XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              DEPTH    = 4
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid_o,
    input  logic            imem_req_ready_i,
    output logic [XLEN-1:0] imem_req_addr_o,
    input  logic            imem_rsp_valid_i,
    input  logic [31:0]     imem_rsp_data_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            if_valid_o,
    input  logic            if_ready_i,
    output logic [31:0]     if_instr_o,
    output logic [XLEN-1:0] if_pc_o
);
    localparam logic [31:0]   NOP      = 32'h00000013;
    localparam int            CW       = $clog2(DEPTH + 1);
    localparam int            PW       = $clog2(DEPTH);
    localparam logic [CW:0]   DEPTH_C  = (CW + 1)'(DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d, rsp_pc_q, rsp_pc_d;
    logic [CW-1:0]   outstanding_q, outstanding_d, drop_cnt_q, drop_cnt_d, count_q, count_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [XLEN-1:0] fifo_pc_q    [DEPTH];
    logic [31:0]     fifo_instr_q [DEPTH];
    logic [XLEN-1:0] redir_pc;
    logic [CW:0]     credit_used;
    logic            req_hs, rsp_v, push, pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PW'(1);
    endfunction

    // Credits cover both buffered and in-flight words, so responses can never overflow the FIFO.
    assign credit_used      = {1'b0, outstanding_q} + {1'b0, count_q};
    assign imem_req_valid_o = !rst && (credit_used < DEPTH_C);
    assign imem_req_addr_o  = fetch_pc_q;
    assign req_hs           = imem_req_valid_o && imem_req_ready_i;
    assign rsp_v            = imem_rsp_valid_i && !rst;
    assign redir_pc         = redirect_pc_i & ~XLEN'(3);

    assign if_valid_o = (count_q != '0);
    assign if_instr_o = if_valid_o ? fifo_instr_q[rd_ptr_q] : NOP;
    assign if_pc_o    = if_valid_o ? fifo_pc_q[rd_ptr_q] : '0;
    assign pop        = if_valid_o && if_ready_i;
    assign push       = rsp_v && (drop_cnt_q == '0) && !redirect_i;

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        rsp_pc_d      = rsp_pc_q;
        drop_cnt_d    = drop_cnt_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        outstanding_d = outstanding_q + CW'(req_hs) - CW'(rsp_v);
        count_d       = count_q + CW'(push) - CW'(pop);
        if (req_hs)
            fetch_pc_d = fetch_pc_q + XLEN'(4);
        if (rsp_v && (drop_cnt_q != '0))
            drop_cnt_d = drop_cnt_q - CW'(1);
        if (push) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
            rsp_pc_d = rsp_pc_q + XLEN'(4);
        end
        if (pop)
            rd_ptr_d = ptr_inc(rd_ptr_q);
        // Everything still in flight after this cycle belongs to the old path.
        if (redirect_i) begin
            fetch_pc_d = redir_pc;
            rsp_pc_d   = redir_pc;
            drop_cnt_d = outstanding_q + CW'(req_hs) - CW'(rsp_v);
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
            count_q       <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
            count_q       <= count_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc_q[wr_ptr_q]    <= rsp_pc_q;
            fifo_instr_q[wr_ptr_q] <= imem_rsp_data_i;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: in-order memory model with adjustable latency,
// stream, back-pressure, reset, redirect and memory-stall scenarios.
module tb_fetch_unit;
    localparam int          XLEN  = 64;
    localparam logic [63:0] RPC   = 64'h1000;
    localparam int          DEPTH = 4;
    localparam logic [63:0] NOP   = 64'h13;

    logic            clk = 1'b0;
    logic            rst;
    logic            imem_req_valid_o, imem_req_ready_i;
    logic [XLEN-1:0] imem_req_addr_o;
    logic            imem_rsp_valid_i;
    logic [31:0]     imem_rsp_data_i;
    logic            redirect_i;
    logic [XLEN-1:0] redirect_pc_i;
    logic            if_valid_o, if_ready_i;
    logic [31:0]     if_instr_o;
    logic [XLEN-1:0] if_pc_o;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    fetch_unit #(.XLEN(XLEN), .RESET_PC(RPC), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid_o(imem_req_valid_o), .imem_req_ready_i(imem_req_ready_i),
        .imem_req_addr_o(imem_req_addr_o),
        .imem_rsp_valid_i(imem_rsp_valid_i), .imem_rsp_data_i(imem_rsp_data_i),
        .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
        .if_valid_o(if_valid_o), .if_ready_i(if_ready_i),
        .if_instr_o(if_instr_o), .if_pc_o(if_pc_o)
    );

    function automatic logic [31:0] word_at(input logic [63:0] a);
        return a[31:0] ^ 32'h00500093;
    endfunction

    // In-order memory: a request accepted at an edge answers mem_lat cycles later.
    typedef struct { logic [63:0] addr; int due; } req_t;
    req_t        mq[$];
    int          tick = 0;
    int          mem_lat = 1;
    logic        mem_v = 1'b0;
    logic [31:0] mem_d = '0;
    assign imem_rsp_valid_i = mem_v;
    assign imem_rsp_data_i  = mem_d;

    always @(posedge clk) begin
        tick  <= tick + 1;
        mem_v <= 1'b0;
        if (rst) mq.delete();
        else begin
            if (imem_req_valid_o && imem_req_ready_i)
                mq.push_back('{imem_req_addr_o, tick + mem_lat});
            if (mq.size() > 0 && mq[0].due <= tick + 1) begin
                mem_v <= 1'b1;
                mem_d <= word_at(mq[0].addr);
                void'(mq.pop_front());
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_valid(input int max);
        for (int i = 0; i < max && !if_valid_o; i++) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; imem_req_ready_i = 1'b1; redirect_i = 1'b0;
        redirect_pc_i = '0; if_ready_i = 1'b1;
        cyc(2);
        chk("rst req_valid", 64'(imem_req_valid_o), 0);
        chk("rst if_valid", 64'(if_valid_o), 0);
        chk("rst if_instr", 64'(if_instr_o), NOP);
        chk("rst if_pc", if_pc_o, 0);
        chk("rst count", 64'(dut.count_q), 0);

        // Reset and stream
        rst = 1'b0; #1;
        chk("first req_valid", 64'(imem_req_valid_o), 1);
        chk("first req addr", imem_req_addr_o, 64'h1000);
        cyc(1);
        chk("latency if_valid low", 64'(if_valid_o), 0);
        chk("second req addr", imem_req_addr_o, 64'h1004);
        cyc(1);
        for (int i = 0; i < 5; i++) begin
            chk("stream valid", 64'(if_valid_o), 1);
            chk("stream pc", if_pc_o, 64'h1000 + 64'(4 * i));
            chk("stream instr", 64'(if_instr_o), 64'(word_at(64'h1000 + 64'(4 * i))));
            cyc(1);
        end

        // Back-pressure
        chk("bp head pc", if_pc_o, 64'h1014);
        if_ready_i = 1'b0;
        cyc(10);
        chk("bp req stalled", 64'(imem_req_valid_o), 0);
        chk("bp head held", if_pc_o, 64'h1014);
        chk("bp count full", 64'(dut.count_q), 4);
        if_ready_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("bp release valid", 64'(if_valid_o), 1);
            chk("bp release pc", if_pc_o, 64'h1014 + 64'(4 * i));
            cyc(1);
        end

        // Mid-operation reset with the FIFO full
        if_ready_i = 1'b0;
        cyc(5);
        chk("refill count", 64'(dut.count_q), 4);
        rst = 1'b1; mem_lat = 3;
        cyc(1);
        chk("midrst if_valid", 64'(if_valid_o), 0);
        chk("midrst count", 64'(dut.count_q), 0);
        chk("midrst req_valid", 64'(imem_req_valid_o), 0);
        rst = 1'b0; if_ready_i = 1'b1; #1;
        chk("midrst restart addr", imem_req_addr_o, RPC);

        // Redirect with two requests in flight, 3-cycle memory
        cyc(2);
        chk("redir outstanding", 64'(dut.outstanding_q), 2);
        imem_req_ready_i = 1'b0; redirect_i = 1'b1; redirect_pc_i = 64'h2002;
        cyc(1);
        redirect_i = 1'b0; imem_req_ready_i = 1'b1;
        chk("redir new addr", imem_req_addr_o, 64'h2000);
        chk("redir if_valid R+1", 64'(if_valid_o), 0);
        chk("redir drop_cnt", 64'(dut.drop_cnt_q), 2);
        cyc(2);
        chk("redir drained drop", 64'(dut.drop_cnt_q), 0);
        chk("redir stale not pushed", 64'(dut.count_q), 0);
        wait_valid(10);
        chk("redir first valid", 64'(if_valid_o), 1);
        chk("redir first pc", if_pc_o, 64'h2000);
        chk("redir first instr", 64'(if_instr_o), 64'(word_at(64'h2000)));

        // Redirect coinciding with response, request handshake and pop
        rst = 1'b1; mem_lat = 1;
        cyc(1);
        rst = 1'b0;
        cyc(3);
        chk("coinc head pc", if_pc_o, 64'h1004);
        chk("coinc outstanding", 64'(dut.outstanding_q), 1);
        redirect_i = 1'b1; redirect_pc_i = 64'h3000;
        cyc(1);
        redirect_i = 1'b0;
        chk("coinc drop_cnt", 64'(dut.drop_cnt_q), 1);
        chk("coinc fifo empty", 64'(dut.count_q), 0);
        chk("coinc if_valid", 64'(if_valid_o), 0);
        chk("coinc new addr", imem_req_addr_o, 64'h3000);
        wait_valid(10);
        chk("coinc first pc", if_pc_o, 64'h3000);
        chk("coinc steady addr", imem_req_addr_o, 64'h3008);

        // Memory stall
        imem_req_ready_i = 1'b0;
        cyc(2);
        chk("mstall drained valid", 64'(if_valid_o), 0);
        chk("mstall nop", 64'(if_instr_o), NOP);
        chk("mstall pc zero", if_pc_o, 0);
        chk("mstall addr held a", imem_req_addr_o, 64'h3008);
        cyc(3);
        chk("mstall addr held b", imem_req_addr_o, 64'h3008);
        chk("mstall req_valid", 64'(imem_req_valid_o), 1);
        imem_req_ready_i = 1'b1;
        wait_valid(10);
        chk("mstall resume valid", 64'(if_valid_o), 1);
        chk("mstall resume pc", if_pc_o, 64'h3008);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
